// File: rtl/alu_pkg.sv
// Shared decode constants, FSM encoding and ALU evaluation helpers for alu_mc.
// Imported by the decoder and the top-level FSM/datapath.
package alu_pkg;

   localparam int unsigned XLEN    = 32;
   localparam int unsigned SHAMT_W = 5;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_SLL  = 4'd2,
      OP_SLT  = 4'd3,
      OP_SLTU = 4'd4,
      OP_XOR  = 4'd5,
      OP_SRL  = 4'd6,
      OP_SRA  = 4'd7,
      OP_OR   = 4'd8,
      OP_AND  = 4'd9
   } alu_op_t;

   // Single-cycle result for every operation, shifts done with a full barrel shifter
   function automatic logic [XLEN-1:0] alu_eval(input alu_op_t op,
                                                input logic [XLEN-1:0] a,
                                                input logic [XLEN-1:0] b);
      logic [SHAMT_W-1:0] sh;
      logic [XLEN-1:0]    r;
      sh = b[SHAMT_W-1:0];
      case (op)
         OP_ADD:  r = a + b;
         OP_SUB:  r = a - b;
         OP_SLL:  r = a << sh;
         OP_SLT:  r = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
         OP_SLTU: r = {{(XLEN-1){1'b0}}, (a < b)};
         OP_XOR:  r = a ^ b;
         OP_SRL:  r = a >> sh;
         OP_SRA:  r = XLEN'($signed(a) >>> sh);
         OP_OR:   r = a | b;
         OP_AND:  r = a & b;
         default: r = '0;
      endcase
      return r;
   endfunction

   // One step of the iterative shifter
   function automatic logic [XLEN-1:0] shift_one(input alu_op_t op,
                                                 input logic [XLEN-1:0] a);
      logic [XLEN-1:0] r;
      case (op)
         OP_SLL:  r = {a[XLEN-2:0], 1'b0};
         OP_SRL:  r = {1'b0, a[XLEN-1:1]};
         OP_SRA:  r = {a[XLEN-1], a[XLEN-1:1]};
         default: r = a;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/alu_mc_decode.sv
// Combinational RV32I OP / OP-IMM decoder: operation select, shift flag and legality.
module alu_mc_decode
   import alu_pkg::*;
(
   input  logic [XLEN-1:0] instr,
   output alu_op_t         op_sel_c,
   output logic            is_shift_c,
   output logic            illegal_c
);

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic       f7_ok;
   logic       alt;
   logic       unused_fields;

   assign opcode        = instr[6:0];
   assign funct3        = instr[14:12];
   assign funct7        = instr[31:25];
   assign alt           = instr[30];
   assign f7_ok         = (funct7 == F7_BASE) || (funct7 == F7_ALT);
   assign unused_fields = ^{instr[24:15], instr[11:7]};

   always_comb begin
      op_sel_c   = OP_ADD;
      is_shift_c = 1'b0;
      illegal_c  = 1'b0;

      case (funct3)
         F3_ADD:  op_sel_c = (opcode == OPC_OP && alt) ? OP_SUB : OP_ADD;
         F3_SLL: begin
            op_sel_c   = OP_SLL;
            is_shift_c = 1'b1;
         end
         F3_SLT:  op_sel_c = OP_SLT;
         F3_SLTU: op_sel_c = OP_SLTU;
         F3_XOR:  op_sel_c = OP_XOR;
         F3_SR: begin
            op_sel_c   = alt ? OP_SRA : OP_SRL;
            is_shift_c = 1'b1;
         end
         F3_OR:   op_sel_c = OP_OR;
         default: op_sel_c = OP_AND;
      endcase

      // ADDI and friends carry immediate bits in funct7, so only shift-immediates are checked
      if (opcode == OPC_OP) begin
         illegal_c = !f7_ok || ((funct7 == F7_ALT) && (funct3 != F3_ADD) && (funct3 != F3_SR));
      end else if (opcode == OPC_OP_IMM) begin
         illegal_c = ((funct3 == F3_SLL) || (funct3 == F3_SR)) && !f7_ok;
      end else begin
         illegal_c = 1'b1;
      end

      if (illegal_c) begin
         is_shift_c = 1'b0;
      end
   end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle RV32I integer ALU: valid/ready request, one result per request,
// shifts either single-cycle or one bit per cycle depending on FAST_SHIFT.
module alu_mc
   import alu_pkg::*;
#(
   parameter bit FAST_SHIFT = 1'b0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] instr,
   input  logic [XLEN-1:0] op1,
   input  logic [XLEN-1:0] op2,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] res,
   output logic            illegal
);

   state_t             state_q, state_d;
   alu_op_t            op_q, op_d;
   logic [SHAMT_W-1:0] cnt_q, cnt_d;
   logic [XLEN-1:0]    res_d;
   logic               illegal_d;

   alu_op_t            dec_op;
   logic               dec_shift;
   logic               dec_illegal;
   logic [SHAMT_W-1:0] shamt;

   assign shamt = op2[SHAMT_W-1:0];

   alu_mc_decode u_decode (
      .instr      (instr),
      .op_sel_c   (dec_op),
      .is_shift_c (dec_shift),
      .illegal_c  (dec_illegal)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and datapath; the result register doubles as the iterative shift register
   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      cnt_d     = cnt_q;
      res_d     = res;
      illegal_d = illegal;

      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               op_d      = dec_op;
               illegal_d = dec_illegal;
               if (dec_illegal) begin
                  res_d   = '0;
                  state_d = ST_DONE;
               end else if (dec_shift && !FAST_SHIFT && (shamt != '0)) begin
                  res_d   = op1;
                  cnt_d   = shamt;
                  state_d = ST_SHIFT;
               end else begin
                  res_d   = alu_eval(dec_op, op1, op2);
                  state_d = ST_DONE;
               end
            end
         end
         ST_SHIFT: begin
            res_d = shift_one(op_q, res);
            cnt_d = cnt_q - SHAMT_W'(1);
            if (cnt_q == SHAMT_W'(1)) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Handshake flags are registered from the next state so they track state_q exactly
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q      <= OP_ADD;
         cnt_q     <= '0;
         res       <= '0;
         illegal   <= 1'b0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
      end else begin
         op_q      <= op_d;
         cnt_q     <= cnt_d;
         res       <= res_d;
         illegal   <= illegal_d;
         in_ready  <= (state_d == ST_IDLE);
         out_valid <= (state_d == ST_DONE);
      end
   end

endmodule

// File: tb/tb_alu_mc.sv
// Directed self-checking bench for alu_mc with the iterative shifter.
module tb_alu_mc;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] instr;
   logic [31:0] op1;
   logic [31:0] op2;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] res;
   logic        illegal;

   int n_tests = 0;
   int n_fail  = 0;

   alu_mc #(.FAST_SHIFT(1'b0)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .instr     (instr),
      .op1       (op1),
      .op2       (op2),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .res       (res),
      .illegal   (illegal)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Issue one request at a falling edge, scramble inputs, then wait for the result
   task automatic run_op(input string tag, input logic [31:0] i, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res,
                         input logic exp_ill, input int exp_lat, input bit finish_hs);
      int   lat;
      logic busy;
      check({tag, " in_ready"}, 32'(in_ready), 32'd1);
      instr    = i;
      op1      = a;
      op2      = b;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      instr    = $urandom;
      op1      = $urandom;
      op2      = $urandom;
      lat      = 1;
      busy     = in_ready;
      while (!out_valid && lat < 64) begin
         @(negedge clk);
         lat++;
         busy = busy | in_ready;
      end
      check({tag, " latency"}, 32'(lat), 32'(exp_lat));
      check({tag, " res"}, res, exp_res);
      check({tag, " illegal"}, 32'(illegal), 32'(exp_ill));
      check({tag, " busy"}, 32'(busy), 32'd0);
      if (finish_hs) begin
         @(negedge clk);
         check({tag, " idle"}, 32'(out_valid), 32'd0);
      end
   endtask

   initial begin
      logic seen;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      instr     = '0;
      op1       = '0;
      op2       = '0;
      out_ready = 1'b1;

      #1;
      check("rst out_valid", 32'(out_valid), 32'd0);
      check("rst res", res, 32'd0);
      check("rst illegal", 32'(illegal), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst in_ready", 32'(in_ready), 32'd1);

      run_op("add",   32'h002081B3, 32'd5,        32'd7,        32'h0000000C, 1'b0, 1,  1'b1);
      run_op("sub",   32'h402081B3, 32'd5,        32'd7,        32'hFFFFFFFE, 1'b0, 1,  1'b1);
      run_op("sra",   32'h4020D1B3, 32'h80000000, 32'd4,        32'hF8000000, 1'b0, 5,  1'b1);
      run_op("sll0",  32'h002091B3, 32'h12345678, 32'h00000020, 32'h12345678, 1'b0, 1,  1'b1);
      run_op("sltu",  32'h0020B1B3, 32'hFFFFFFFF, 32'd1,        32'h00000000, 1'b0, 1,  1'b1);
      run_op("slt",   32'h0020A1B3, 32'hFFFFFFFF, 32'd1,        32'h00000001, 1'b0, 1,  1'b1);
      run_op("xor",   32'h0020C1B3, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1,  1'b1);
      run_op("or",    32'h0020E1B3, 32'hF0F0F0F0, 32'h0F00000F, 32'hFFF0F0FF, 1'b0, 1,  1'b1);
      run_op("and",   32'h0020F1B3, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1,  1'b1);
      run_op("addwr", 32'h002081B3, 32'hFFFFFFFF, 32'd1,        32'h00000000, 1'b0, 1,  1'b1);
      run_op("addi",  32'h40008193, 32'd10,       32'h00000400, 32'h0000040A, 1'b0, 1,  1'b1);
      run_op("srli",  32'h0040D193, 32'h80000000, 32'd4,        32'h08000000, 1'b0, 5,  1'b1);
      run_op("srai",  32'h4040D193, 32'h80000010, 32'd4,        32'hF8000001, 1'b0, 5,  1'b1);
      run_op("sll31", 32'h002091B3, 32'd1,        32'h0000001F, 32'h80000000, 1'b0, 32, 1'b1);
      run_op("sllhi", 32'h002091B3, 32'd1,        32'hFFFFFFE1, 32'h00000002, 1'b0, 2,  1'b1);
      run_op("ill03", 32'h00000003, 32'h11111111, 32'h22222222, 32'h00000000, 1'b1, 1,  1'b1);
      run_op("illxr", 32'h4020C1B3, 32'h11111111, 32'h22222222, 32'h00000000, 1'b1, 1,  1'b1);
      run_op("illsh", 32'h02009193, 32'h11111111, 32'h22222222, 32'h00000000, 1'b1, 1,  1'b1);
      run_op("illmu", 32'h022081B3, 32'h11111111, 32'h22222222, 32'h00000000, 1'b1, 1,  1'b1);

      // Backpressure: result held, new requests ignored while stalled
      out_ready = 1'b0;
      run_op("bp", 32'h002081B3, 32'd5, 32'd7, 32'h0000000C, 1'b0, 1, 1'b0);
      for (int c = 0; c < 3; c++) begin
         in_valid = 1'b1;
         instr    = 32'h402081B3;
         op1      = 32'hDEADBEEF;
         op2      = 32'h00000001;
         @(negedge clk);
         check("bp hold res", res, 32'h0000000C);
         check("bp hold illegal", 32'(illegal), 32'd0);
         check("bp hold valid", 32'(out_valid), 32'd1);
         check("bp in_ready", 32'(in_ready), 32'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      check("bp release valid", 32'(out_valid), 32'd0);
      check("bp release ready", 32'(in_ready), 32'd1);
      check("bp no capture", res, 32'h0000000C);

      // Reset in the middle of a long iterative shift
      instr    = 32'h002091B3;
      op1      = 32'd1;
      op2      = 32'd20;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      check("abort busy", 32'(in_ready), 32'd0);
      rst_n = 1'b0;
      #1;
      check("abort out_valid", 32'(out_valid), 32'd0);
      check("abort res", res, 32'd0);
      check("abort illegal", 32'(illegal), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      seen  = 1'b0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         seen = seen | out_valid;
      end
      check("abort no result", 32'(seen), 32'd0);
      check("abort in_ready", 32'(in_ready), 32'd1);

      run_op("post", 32'h402081B3, 32'd0, 32'd1, 32'hFFFFFFFF, 1'b0, 1, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 FAST_SHIFT, 0, when 1 all shifts complete with single-cycle latency; when 0 shifts run iteratively, one bit per cycle.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  request valid (initiator side).
REQ-005 in_ready  output  1  block can accept a request.
REQ-006 instr  input  32  RV32I instruction word (OP or OP-IMM).
REQ-007 op1  input  32  rs1 value.
REQ-008 op2  input  32  rs2 value or sign-extended immediate.
REQ-009 out_valid  output  1  result valid.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 res  output  32  result.
REQ-012 illegal  output  1  qualifies res; unsupported instruction.

Function
REQ-013 Request accepted in cycle k when in_valid && in_ready; instr/op1/op2 SHALL be captured at the end of cycle k and need not be held afterwards.
REQ-014 FSM states IDLE, SHIFT, DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-015 IDLE -> DONE on accept of non-shift, illegal, shamt=0 shift, or any shift with FAST_SHIFT=1; IDLE -> SHIFT on accept of shift with shamt>0 and FAST_SHIFT=0.
REQ-016 SHIFT: each cycle shift 1 bit (SLL left zero-fill, SRL right zero-fill, SRA right sign-fill) and decrement 5-bit counter; -> DONE on the edge where counter goes 1->0.
REQ-017 DONE -> IDLE on out_valid && out_ready; res/illegal SHALL stay stable while out_valid && !out_ready.
REQ-018 Latency: out_valid first high in cycle k+1 for single-cycle cases, k+1+shamt for iterative shifts; no overlap, next accept earliest the cycle after the output handshake.
REQ-019 Decode: opcode 0110011 (OP) and 0010011 (OP-IMM); funct3 000 ADD/SUB, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA, 110 OR, 111 AND.
REQ-020 instr[30]=1 selects SUB only for OP funct3 000, SRA for funct3 101 (both opcodes); ADDI ignores instr[31:25].
REQ-021 Illegal: other opcode; OP with funct7 not 0000000/0100000 or 0100000 with funct3 not 000/101; shift-immediate with funct7 not 0000000/0100000 -> res=0, illegal=1, latency 1.
REQ-022 Arithmetic modulo 2^32; SLT signed, SLTU unsigned, result 0 or 1; shamt = op2[4:0], op2[31:5] ignored.
REQ-023 in_valid while not in IDLE SHALL be ignored (no capture, no state change).

Reset
REQ-024 rst_n low SHALL immediately force state IDLE, out_valid=0, res=0, illegal=0, counter=0; in_ready=1 after release.
REQ-025 Reset during SHIFT or DONE SHALL abort the operation with no result delivered.

Structure
REQ-026 Opcode, funct3, funct7 constants and the FSM state encoding SHALL live in shared package alu_pkg.
REQ-027 Combinational decode SHALL be sub-module alu_mc_decode (instr -> op select, is_shift, illegal); FSM and datapath in alu_mc.

Verification
REQ-028 ADD instr 0x002081B3, op1 5, op2 7, out_ready=1 -> res 0x0000000C, illegal 0, out_valid in cycle k+1.
REQ-029 SUB instr 0x402081B3, op1 5, op2 7 -> res 0xFFFFFFFE, latency 1.
REQ-030 SRA instr 0x4020D1B3, op1 0x80000000, op2 4, FAST_SHIFT=0 -> res 0xF8000000, out_valid first in cycle k+5, in_ready low cycles k+1..k+5.
REQ-031 SLL shamt 0 (op2 0x00000020) op1 0x12345678 -> res 0x12345678, latency 1; SLTU op1 0xFFFFFFFF op2 1 -> res 0.
REQ-032 Backpressure: out_ready=0 for 3 cycles after out_valid -> res/illegal constant, in_ready 0, new in_valid ignored; out_ready=1 -> IDLE next cycle.
REQ-033 Illegal instr 0x00000003 -> res 0, illegal 1; rst_n low mid-SHIFT -> out_valid 0 immediately, no result after release.
